// File: rtl/sonar_sequenciador.sv
// -----------------------------------------------------------------------------
// sonar_sequenciador
// Sweep controller for the sonar datapath. Steps the servo through a ping-pong
// sweep, waits a settling time at each position, runs one distance measurement
// (retrying on echo timeout) and then streams a fixed-length frame through the
// serial transmitter one byte at a time.
//
// Ports
//   clock_i          system clock, rising edge
//   reset_i          asynchronous active-low reset
//   ligar_i          level, enables the sweep (sampled in INICIAL / FIM_POSICAO)
//   sensor_pronto_i  pulse: measurement done (used only in AGUARDA_MEDIDA)
//   serial_pronto_i  pulse: byte sent (used only in AGUARDA_TX)
//   medir_o          pulse: start a measurement (high during MEDE)
//   transmitir_o     pulse: start a byte transmission (cycle after TRANSMITE)
//   sel_posicao_o    current servo position index
//   sel_byte_o       frame byte index being sent
//   erro_timeout_o   distance invalid for the current frame
//   fim_posicao_o    pulse: frame complete (high during FIM_POSICAO)
//   db_estado_o      state code for debug
// -----------------------------------------------------------------------------
module sonar_sequenciador #(
    parameter int N_POS          = 8,
    parameter int SETTLE_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int N_RETRY        = 1,
    parameter int N_BYTES        = 8
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       ligar_i,
    input  logic       sensor_pronto_i,
    input  logic       serial_pronto_i,
    output logic       medir_o,
    output logic       transmitir_o,
    output logic [2:0] sel_posicao_o,
    output logic [2:0] sel_byte_o,
    output logic       erro_timeout_o,
    output logic       fim_posicao_o,
    output logic [3:0] db_estado_o
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        POSICIONA      = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_TX     = 4'd5,
        FIM_POSICAO    = 4'd6
    } estado_t;

    estado_t       estado_q;
    logic [SW-1:0] settle_q;
    logic [TW-1:0] tmo_q;
    logic [1:0]    retry_q;
    logic          dir_up_q;
    logic [2:0]    pos_q;
    logic [2:0]    byte_q;
    logic          medir_q;
    logic          tx_q;
    logic          fim_q;
    logic          erro_q;

    // Next sweep position: bounce at both ends, frozen at 0 for a single position.
    logic [2:0] pos_d;
    logic       dir_up_d;
    always_comb begin
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        if (N_POS > 1) begin
            if (dir_up_q) begin
                if (pos_q == 3'(N_POS - 1)) begin
                    dir_up_d = 1'b0;
                    pos_d    = pos_q - 3'd1;
                end else begin
                    pos_d = pos_q + 3'd1;
                end
            end else if (pos_q == 3'd0) begin
                dir_up_d = 1'b1;
                pos_d    = 3'd1;
            end else begin
                pos_d = pos_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            estado_q <= INICIAL;
            settle_q <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            dir_up_q <= 1'b1;
            pos_q    <= '0;
            byte_q   <= '0;
            medir_q  <= 1'b0;
            tx_q     <= 1'b0;
            fim_q    <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            // Pulse outputs default low; set on entry to their state.
            medir_q <= 1'b0;
            tx_q    <= 1'b0;
            fim_q   <= 1'b0;
            case (estado_q)
                INICIAL: begin
                    if (ligar_i) begin
                        estado_q <= POSICIONA;
                        settle_q <= '0;
                        retry_q  <= '0;
                        erro_q   <= 1'b0;
                    end
                end
                POSICIONA: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        estado_q <= MEDE;
                        medir_q  <= 1'b1;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                MEDE: begin
                    tmo_q    <= '0;
                    estado_q <= AGUARDA_MEDIDA;
                end
                AGUARDA_MEDIDA: begin
                    // A result arriving on the timeout cycle still counts as valid.
                    if (sensor_pronto_i) begin
                        estado_q <= TRANSMITE;
                        byte_q   <= '0;
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        if (retry_q < 2'(N_RETRY)) begin
                            retry_q  <= retry_q + 1'b1;
                            estado_q <= MEDE;
                            medir_q  <= 1'b1;
                        end else begin
                            erro_q   <= 1'b1;
                            estado_q <= TRANSMITE;
                            byte_q   <= '0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                TRANSMITE: begin
                    // transmitir rises the cycle after TRANSMITE, once sel_byte is settled.
                    tx_q     <= 1'b1;
                    estado_q <= AGUARDA_TX;
                end
                AGUARDA_TX: begin
                    if (serial_pronto_i) begin
                        if (byte_q == 3'(N_BYTES - 1)) begin
                            estado_q <= FIM_POSICAO;
                            fim_q    <= 1'b1;
                        end else begin
                            byte_q   <= byte_q + 1'b1;
                            estado_q <= TRANSMITE;
                        end
                    end
                end
                FIM_POSICAO: begin
                    pos_q    <= pos_d;
                    dir_up_q <= dir_up_d;
                    erro_q   <= 1'b0;
                    retry_q  <= '0;
                    settle_q <= '0;
                    estado_q <= ligar_i ? POSICIONA : INICIAL;
                end
                default: estado_q <= INICIAL;
            endcase
        end
    end

    assign medir_o        = medir_q;
    assign transmitir_o   = tx_q;
    assign fim_posicao_o  = fim_q;
    assign erro_timeout_o = erro_q;
    assign sel_posicao_o  = pos_q;
    assign sel_byte_o     = byte_q;
    assign db_estado_o    = estado_q;

endmodule
